// File: rtl/operand_stage.sv
// Decode->execute operand stage: builds immediates, selects ALU operands, precomputes the
// branch/jump target and tracks in-flight load destinations for load-use stalls.
module operand_stage #(
    parameter int XLEN       = 64,
    parameter int PEND_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       raw_instr,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              uses_rs1,
    input  logic              uses_rs2,
    input  logic [2:0]        imm_fmt,
    input  logic [2:0]        opsel,
    input  logic              is_load,
    input  logic              ld_done,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [XLEN-1:0]   out_sdata,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_target,
    output logic [4:0]        out_rd,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PTR_W = $clog2(PEND_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;

    localparam logic [2:0] SEL_REG   = 3'd0;
    localparam logic [2:0] SEL_RIMM  = 3'd1;
    localparam logic [2:0] SEL_LUI   = 3'd2;
    localparam logic [2:0] SEL_AUIPC = 3'd3;
    localparam logic [2:0] SEL_LINK  = 3'd4;
    localparam logic [2:0] SEL_WSEXT = 3'd5;
    localparam logic [2:0] SEL_WZEXT = 3'd6;

    function automatic logic signed [31:0] imm_gen(input logic [31:0] ins, input logic [2:0] fmt);
        logic signed [31:0] r;
        case (fmt)
            FMT_I:   r = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   r = {ins[31:12], 12'b0};
            FMT_J:   r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0] s;
        s = signed'(v);
        return XLEN'(s);
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [4:0] rd_idx, rs1_idx, rs2_idx;
    logic       unused_opcode;

    assign rd_idx        = raw_instr[11:7];
    assign rs1_idx       = raw_instr[19:15];
    assign rs2_idx       = raw_instr[24:20];
    assign unused_opcode = ^raw_instr[6:0];

    // ---- p0: combinational decode of the incoming instruction ----
    logic signed [31:0] imm32_p0;
    logic [XLEN-1:0]    imm_p0, target_p0, op1_p0, op2_p0;

    assign imm32_p0  = imm_gen(raw_instr, imm_fmt);
    assign imm_p0    = sext32(imm32_p0);
    assign target_p0 = pc + imm_p0;

    always_comb begin
        op1_p0 = rs1_data;
        op2_p0 = rs2_data;
        case (opsel)
            SEL_RIMM:  begin op1_p0 = rs1_data;          op2_p0 = imm_p0;             end
            SEL_LUI:   begin op1_p0 = '0;                op2_p0 = imm_p0;             end
            SEL_AUIPC: begin op1_p0 = pc;                op2_p0 = imm_p0;             end
            SEL_LINK:  begin op1_p0 = pc;                op2_p0 = XLEN'(3'd4);        end
            SEL_WSEXT: begin op1_p0 = sext32(rs1_data[31:0]); op2_p0 = sext32(rs2_data[31:0]); end
            SEL_WZEXT: begin op1_p0 = zext32(rs1_data[31:0]); op2_p0 = zext32(rs2_data[31:0]); end
            default:   begin op1_p0 = rs1_data;          op2_p0 = rs2_data;           end
        endcase
    end

    // Load-use scoreboard: FIFO of pending load destinations with a per-slot valid bit.
    logic [4:0]            sb_rd [PEND_DEPTH];
    logic [PEND_DEPTH-1:0] sb_vld, sb_vld_nxt;
    logic [PTR_W-1:0]      sb_head, sb_tail;
    logic [OCC_W-1:0]      sb_occ;
    logic                  sb_full, sb_push, sb_pop;
    logic                  hit_rs1, hit_rs2, hazard, ld_block, accept;
    logic                  vld_p1;

    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            if (sb_vld[i] && (sb_rd[i] == rs1_idx)) hit_rs1 = 1'b1;
            if (sb_vld[i] && (sb_rd[i] == rs2_idx)) hit_rs2 = 1'b1;
        end
    end

    assign hazard   = (uses_rs1 && (rs1_idx != 5'd0) && hit_rs1) ||
                      (uses_rs2 && (rs2_idx != 5'd0) && hit_rs2);
    assign sb_full  = (sb_occ == OCC_W'(PEND_DEPTH));
    // A full scoreboard only admits a new load if a slot frees up this same cycle.
    assign ld_block = is_load && (rd_idx != 5'd0) && sb_full && !ld_done;
    assign in_ready = !hazard && !ld_block && (!vld_p1 || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign sb_push  = accept && is_load && (rd_idx != 5'd0);
    assign sb_pop   = ld_done && (sb_occ != '0) && !flush;

    always_comb begin
        sb_vld_nxt = sb_vld;
        if (sb_pop)  sb_vld_nxt[sb_head] = 1'b0;
        if (sb_push) sb_vld_nxt[sb_tail] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_vld  <= '0;
            sb_head <= '0;
            sb_tail <= '0;
            sb_occ  <= '0;
        end else if (flush) begin
            sb_vld  <= '0;
            sb_head <= '0;
            sb_tail <= '0;
            sb_occ  <= '0;
        end else begin
            sb_vld <= sb_vld_nxt;
            if (sb_pop)  sb_head <= sb_head + 1'b1;
            if (sb_push) sb_tail <= sb_tail + 1'b1;
            case ({sb_push, sb_pop})
                2'b10:   sb_occ <= sb_occ + 1'b1;
                2'b01:   sb_occ <= sb_occ - 1'b1;
                default: sb_occ <= sb_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sb_push) sb_rd[sb_tail] <= rd_idx;
    end

    // ---- p1: registered operands toward execute ----
    logic [XLEN-1:0]  op1_p1, op2_p1, sdata_p1, imm_p1, target_p1;
    logic [4:0]       rd_p1;
    logic [CNT_W-1:0] stall_p1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1    <= 1'b0;
            op1_p1    <= '0;
            op2_p1    <= '0;
            sdata_p1  <= '0;
            imm_p1    <= '0;
            target_p1 <= '0;
            rd_p1     <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            op1_p1    <= op1_p0;
            op2_p1    <= op2_p0;
            sdata_p1  <= rs2_data;
            imm_p1    <= imm_p0;
            target_p1 <= target_p0;
            rd_p1     <= rd_idx;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_p1 <= '0;
        end else if (in_valid && !in_ready) begin
            stall_p1 <= sat_inc(stall_p1);
        end
    end

    assign out_valid  = vld_p1;
    assign out_op1    = op1_p1;
    assign out_op2    = op2_p1;
    assign out_sdata  = sdata_p1;
    assign out_imm    = imm_p1;
    assign out_target = target_p1;
    assign out_rd     = rd_p1;
    assign stall_cnt  = stall_p1;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: reset, decode, operand select, load-use scoreboard,
// backpressure, flush and asynchronous reset.
module tb_operand_stage;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] raw_instr;
    logic [63:0] pc, rs1_data, rs2_data;
    logic        uses_rs1, uses_rs2;
    logic [2:0]  imm_fmt, opsel;
    logic        is_load, ld_done, flush;
    logic        out_valid, out_ready;
    logic [63:0] out_op1, out_op2, out_sdata, out_imm, out_target;
    logic [4:0]  out_rd;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    operand_stage #(.XLEN(64), .PEND_DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .raw_instr(raw_instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .imm_fmt(imm_fmt), .opsel(opsel),
        .is_load(is_load), .ld_done(ld_done), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2), .out_sdata(out_sdata),
        .out_imm(out_imm), .out_target(out_target), .out_rd(out_rd), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] instr, input logic [2:0] fmt, input logic [2:0] sel,
                          input logic u1, input logic u2, input logic ld);
        raw_instr = instr; imm_fmt = fmt; opsel = sel;
        uses_rs1 = u1; uses_rs2 = u2; is_load = ld;
    endtask

    function automatic logic [31:0] enc_ld(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b011, rd, 7'h03};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    task automatic test_reset;
        resetn = 1'b0; in_valid = 1'b0; pc = '0; rs1_data = '0; rs2_data = '0;
        set_op(32'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        ld_done = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick; tick;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0h exp=0", out_valid); else n_pass++;
        n_checks++; if (out_op2 !== 64'h0) $display("FAIL reset_out_op2 got=%0h exp=0", out_op2); else n_pass++;
        n_checks++; if (stall_cnt !== 32'h0) $display("FAIL reset_stall_cnt got=%0h exp=0", stall_cnt); else n_pass++;
        resetn = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0h exp=1", in_ready); else n_pass++;
    endtask

    task automatic test_addi;
        set_op(32'h00500093, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
        rs1_data = '0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL addi_valid got=%0h exp=1", out_valid); else n_pass++;
        n_checks++; if (out_op2 !== 64'd5) $display("FAIL addi_op2 got=%0h exp=5", out_op2); else n_pass++;
        n_checks++; if (out_rd !== 5'd1) $display("FAIL addi_rd got=%0h exp=1", out_rd); else n_pass++;
        tick;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL addi_consumed got=%0h exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_load_use;
        set_op(enc_ld(5'd5, 5'd2), 3'd0, 3'd1, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL lu_load_ready got=%0h exp=1", in_ready); else n_pass++;
        tick;
        set_op(enc_r(5'd6, 5'd5, 5'd0), 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL lu_stall got=%0h exp=0", in_ready); else n_pass++;
        tick;
        n_checks++; if (stall_cnt !== 32'd1) $display("FAIL lu_stall_cnt1 got=%0h exp=1", stall_cnt); else n_pass++;
        ld_done = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL lu_same_cycle_done got=%0h exp=0", in_ready); else n_pass++;
        tick;
        ld_done = 1'b0;
        #1;
        n_checks++; if (stall_cnt !== 32'd2) $display("FAIL lu_stall_cnt2 got=%0h exp=2", stall_cnt); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL lu_released got=%0h exp=1", in_ready); else n_pass++;
        tick;
        in_valid = 1'b0;
        n_checks++; if (out_rd !== 5'd6 || out_valid !== 1'b1) $display("FAIL lu_accept rd=%0h v=%0h exp rd=6 v=1", out_rd, out_valid); else n_pass++;
        n_checks++; if (stall_cnt !== 32'd2) $display("FAIL lu_stall_hold got=%0h exp=2", stall_cnt); else n_pass++;
        tick;
    endtask

    task automatic test_immediates;
        pc = 64'h1000; rs2_data = 64'hCAFE; in_valid = 1'b1;
        set_op(32'hFE000EE3, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0);
        tick;
        n_checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL imm_b got=%0h exp=fffffffffffffffc", out_imm); else n_pass++;
        n_checks++; if (out_target !== 64'hFFC) $display("FAIL target_b got=%0h exp=ffc", out_target); else n_pass++;
        set_op(32'h8000006F, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0);
        tick;
        n_checks++; if (out_imm !== 64'hFFFF_FFFF_FFF0_0000) $display("FAIL imm_j got=%0h exp=fffffffffff00000", out_imm); else n_pass++;
        n_checks++; if (out_target !== 64'hFFFF_FFFF_FFF0_1000) $display("FAIL target_j_wrap got=%0h exp=fffffffffff01000", out_target); else n_pass++;
        set_op(32'hFE003C23, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        tick;
        n_checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFF8) $display("FAIL imm_s got=%0h exp=fffffffffffffff8", out_imm); else n_pass++;
        n_checks++; if (out_sdata !== 64'hCAFE) $display("FAIL sdata got=%0h exp=cafe", out_sdata); else n_pass++;
        set_op(32'h12345037, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0);
        tick;
        n_checks++; if (out_op1 !== 64'h0 || out_op2 !== 64'h1234_5000) $display("FAIL lui op1=%0h op2=%0h exp 0/12345000", out_op1, out_op2); else n_pass++;
        set_op(32'h12345017, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0);
        tick;
        n_checks++; if (out_op1 !== 64'h1000 || out_target !== 64'h1234_6000) $display("FAIL auipc op1=%0h tgt=%0h exp 1000/12346000", out_op1, out_target); else n_pass++;
        set_op(32'h8000006F, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0);
        tick;
        n_checks++; if (out_op1 !== 64'h1000 || out_op2 !== 64'd4) $display("FAIL link op1=%0h op2=%0h exp 1000/4", out_op1, out_op2); else n_pass++;
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_wmodes;
        rs1_data = 64'h0000_0000_8000_0001; rs2_data = 64'h1234_5678_FFFF_FFF0;
        set_op({7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'h3B}, 3'd7, 3'd5, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick;
        n_checks++; if (out_op1 !== 64'hFFFF_FFFF_8000_0001) $display("FAIL wsext_op1 got=%0h exp=ffffffff80000001", out_op1); else n_pass++;
        n_checks++; if (out_op2 !== 64'hFFFF_FFFF_FFFF_FFF0) $display("FAIL wsext_op2 got=%0h exp=fffffffffffffff0", out_op2); else n_pass++;
        opsel = 3'd6;
        tick;
        n_checks++; if (out_op1 !== 64'h0000_0000_8000_0001) $display("FAIL wzext_op1 got=%0h exp=80000001", out_op1); else n_pass++;
        n_checks++; if (out_op2 !== 64'h0000_0000_FFFF_FFF0) $display("FAIL wzext_op2 got=%0h exp=fffffff0", out_op2); else n_pass++;
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_sb_full;
        for (int i = 1; i <= 4; i++) begin
            set_op(enc_ld(5'(i), 5'd0), 3'd0, 3'd1, 1'b1, 1'b0, 1'b1);
            in_valid = 1'b1;
            #1;
            n_checks++; if (in_ready !== 1'b1) $display("FAIL sb_fill%0d got=%0h exp=1", i, in_ready); else n_pass++;
            tick;
        end
        set_op(enc_ld(5'd7, 5'd0), 3'd0, 3'd1, 1'b1, 1'b0, 1'b1);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL sb_full_stall got=%0h exp=0", in_ready); else n_pass++;
        tick;
        ld_done = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL sb_full_same_done got=%0h exp=1", in_ready); else n_pass++;
        tick;
        ld_done = 1'b0; in_valid = 1'b0;
        set_op(enc_r(5'd20, 5'd1, 5'd0), 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL sb_popped_x1 got=%0h exp=1", in_ready); else n_pass++;
        set_op(enc_r(5'd20, 5'd7, 5'd0), 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL sb_x7_pending got=%0h exp=0", in_ready); else n_pass++;
        set_op(enc_ld(5'd8, 5'd0), 3'd0, 3'd1, 1'b1, 1'b0, 1'b1);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL sb_still_full got=%0h exp=0", in_ready); else n_pass++;
        ld_done = 1'b1;
        repeat (6) tick;
        ld_done = 1'b0;
        set_op(enc_r(5'd20, 5'd7, 5'd0), 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL sb_drained got=%0h exp=1", in_ready); else n_pass++;
        for (int i = 9; i <= 12; i++) begin
            set_op(enc_ld(5'(i), 5'd0), 3'd0, 3'd1, 1'b1, 1'b0, 1'b1);
            in_valid = 1'b1;
            #1;
            n_checks++; if (in_ready !== 1'b1) $display("FAIL sb_refill%0d got=%0h exp=1", i, in_ready); else n_pass++;
            tick;
        end
        in_valid = 1'b0;
        set_op(enc_ld(5'd13, 5'd0), 3'd0, 3'd1, 1'b1, 1'b0, 1'b1);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL sb_empty_done_ignored got=%0h exp=0", in_ready); else n_pass++;
        ld_done = 1'b1;
        repeat (4) tick;
        ld_done = 1'b0;
    endtask

    task automatic test_backpressure_flush;
        out_ready = 1'b1; in_valid = 1'b1;
        set_op(enc_ld(5'd10, 5'd0), 3'd0, 3'd1, 1'b1, 1'b0, 1'b1);
        tick;
        set_op(enc_ld(5'd11, 5'd0), 3'd0, 3'd1, 1'b1, 1'b0, 1'b1);
        tick;
        rs1_data = 64'h111;
        set_op({12'h07F, 5'd0, 3'b000, 5'd12, 7'h13}, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
        tick;
        out_ready = 1'b0;
        set_op(enc_r(5'd14, 5'd10, 5'd11), 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        rs1_data = 64'h999;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_c%0d got=%0h exp=0", k, in_ready); else n_pass++;
            tick;
            n_checks++; if (out_valid !== 1'b1 || out_op1 !== 64'h111 || out_op2 !== 64'h7F || out_rd !== 5'd12)
                $display("FAIL bp_hold_c%0d v=%0h op1=%0h op2=%0h rd=%0h exp 1/111/7f/c", k, out_valid, out_op1, out_op2, out_rd);
            else n_pass++;
        end
        flush = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_ready got=%0h exp=0", in_ready); else n_pass++;
        tick;
        flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid got=%0h exp=0", out_valid); else n_pass++;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_sb_cleared got=%0h exp=1", in_ready); else n_pass++;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_rd !== 5'd14 || out_op1 !== 64'h999) $display("FAIL flush_next v=%0h rd=%0h op1=%0h exp 1/e/999", out_valid, out_rd, out_op1); else n_pass++;
        tick;
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1;
        set_op(enc_ld(5'd13, 5'd0), 3'd0, 3'd1, 1'b1, 1'b0, 1'b1);
        tick;
        in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_rd !== 5'd0 || stall_cnt !== 32'd0) $display("FAIL midreset v=%0h rd=%0h sc=%0h exp 0/0/0", out_valid, out_rd, stall_cnt); else n_pass++;
        tick;
        resetn = 1'b1;
        set_op(enc_r(5'd20, 5'd13, 5'd0), 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL midreset_sb_empty got=%0h exp=1", in_ready); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_addi;
        test_load_use;
        test_immediates;
        test_wmodes;
        test_sb_full;
        test_backpressure_flush;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
